// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the ALU issue unit: FSM state encoding, the fixed
//   ALU data width, the default register count and the instruction record
//   used by anything that assembles instructions for the unit.
package alu_issue_pkg;

   localparam int ALU_DW         = 4;
   localparam int NREG_DEFAULT   = 4;
   localparam int REG_AW_DEFAULT = $clog2(NREG_DEFAULT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]                op;
      logic [REG_AW_DEFAULT-1:0] ra;
      logic [REG_AW_DEFAULT-1:0] rb;
      logic [REG_AW_DEFAULT-1:0] rd;
      logic [ALU_DW-1:0]         imm;
      logic                      use_imm;
      logic                      ld;
   } instr_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile
//   NREG x DW register file: one synchronous write port, three asynchronous
//   read ports (operand A, operand B, debug). Asynchronous active-high reset
//   clears every entry.
// Ports:
//   clk_i, rst_i                     clock, async reset
//   we_i, waddr_i, wdata_i           write port
//   raddr_a_i / rdata_a_o            operand A read
//   raddr_b_i / rdata_b_o            operand B read
//   raddr_dbg_i / rdata_dbg_o        debug read
module alu_issue_regfile #(
   parameter int NREG = 4,
   parameter int DW   = 4,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [DW-1:0] rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_b_o,
   input  logic [AW-1:0] raddr_dbg_i,
   output logic [DW-1:0] rdata_dbg_o
);

   logic [DW-1:0] mem_q [NREG];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o   = mem_q[raddr_a_i];
   assign rdata_b_o   = mem_q[raddr_b_i];
   assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Sequencing front end for the 4-bit opcode ALU. Accepts one instruction
//   per valid/ready handshake, reads operands from the register file, drives
//   the ALU inputs from registers and writes the ALU results back, turning
//   the combinational ALU into a three-cycle datapath (IDLE -> ISSUE -> WB).
// Configuration macro:
//   ALU_ISSUE_OVERLAP_EN  accept in WB as well (2-cycle throughput) with
//                         forwarding of the write-back value to operand reads.
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   instr_valid_i / instr_ready_o        instruction handshake
//   instr_op_i, instr_ra_i, instr_rb_i,
//   instr_rd_i, instr_imm_i,
//   instr_use_imm_i, instr_ld_i          instruction fields
//   alu_a_o, alu_b_o, alu_opcode_o       registered ALU inputs
//   alu_x_i, alu_y_i                     ALU results
//   aux_o                                last captured alu_y
//   dbg_addr_i / dbg_data_o              combinational register read
//   busy_o, retire_o, retire_count_o     status
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter int NREG = NREG_DEFAULT,
   parameter int DW   = ALU_DW,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          instr_valid_i,
   output logic          instr_ready_o,
   input  logic [3:0]    instr_op_i,
   input  logic [AW-1:0] instr_ra_i,
   input  logic [AW-1:0] instr_rb_i,
   input  logic [AW-1:0] instr_rd_i,
   input  logic [DW-1:0] instr_imm_i,
   input  logic          instr_use_imm_i,
   input  logic          instr_ld_i,
   output logic [DW-1:0] alu_a_o,
   output logic [DW-1:0] alu_b_o,
   output logic [3:0]    alu_opcode_o,
   input  logic [DW-1:0] alu_x_i,
   input  logic [DW-1:0] alu_y_i,
   output logic [DW-1:0] aux_o,
   input  logic [AW-1:0] dbg_addr_i,
   output logic [DW-1:0] dbg_data_o,
   output logic          busy_o,
   output logic          retire_o,
   output logic [7:0]    retire_count_o
);

   state_e        state_q, state_d;
   logic          accept;
   logic [DW-1:0] alu_a_q, alu_b_q, aux_q, imm_q;
   logic [3:0]    alu_op_q;
   logic [AW-1:0] rd_q;
   logic          ld_q;
   logic [7:0]    retire_count_q;
   logic [DW-1:0] rf_a, rf_b, opnd_a, opnd_b, wb_data;

   assign accept  = instr_valid_i & instr_ready_o;
   // A load writes its latched immediate; everything else writes alu_x.
   assign wb_data = ld_q ? imm_q : alu_x_i;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WB;
         ST_WB:    state_d = accept ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      instr_ready_o = 1'b0;
      busy_o        = 1'b1;
      retire_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_ready_o = 1'b1;
            busy_o        = 1'b0;
         end
         ST_WB: begin
            retire_o = 1'b1;
`ifdef ALU_ISSUE_OVERLAP_EN
            instr_ready_o = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   alu_issue_regfile #(.NREG(NREG), .DW(DW)) u_rf (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .we_i        (retire_o),
      .waddr_i     (rd_q),
      .wdata_i     (wb_data),
      .raddr_a_i   (instr_ra_i),
      .rdata_a_o   (rf_a),
      .raddr_b_i   (instr_rb_i),
      .rdata_b_o   (rf_b),
      .raddr_dbg_i (dbg_addr_i),
      .rdata_dbg_o (dbg_data_o)
   );

`ifdef ALU_ISSUE_OVERLAP_EN
   // An instruction accepted in WB reads the value being written this cycle.
   always_comb begin
      opnd_a = rf_a;
      opnd_b = instr_use_imm_i ? instr_imm_i : rf_b;
      if (state_q == ST_WB) begin
         if (instr_ra_i == rd_q) opnd_a = wb_data;
         if (!instr_use_imm_i && instr_rb_i == rd_q) opnd_b = wb_data;
      end
   end
`else
   // Acceptance only happens in IDLE, after the previous write has committed.
   assign opnd_a = rf_a;
   assign opnd_b = instr_use_imm_i ? instr_imm_i : rf_b;
`endif

   // Datapath registers: ALU inputs load only on acceptance and hold otherwise.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= '0;
         rd_q           <= '0;
         ld_q           <= 1'b0;
         imm_q          <= '0;
         aux_q          <= '0;
         retire_count_q <= '0;
      end else begin
         if (accept) begin
            alu_a_q  <= opnd_a;
            alu_b_q  <= opnd_b;
            alu_op_q <= instr_op_i;
            rd_q     <= instr_rd_i;
            ld_q     <= instr_ld_i;
            imm_q    <= instr_imm_i;
         end
         if (retire_o) begin
            if (!ld_q) aux_q <= alu_y_i;
            retire_count_q <= retire_count_q + 8'd1;
         end
      end
   end

   assign alu_a_o        = alu_a_q;
   assign alu_b_o        = alu_b_q;
   assign alu_opcode_o   = alu_op_q;
   assign aux_o          = aux_q;
   assign retire_count_o = retire_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
//   Directed and randomized bench for alu_issue_unit. A stub ALU answers the
//   unit's registered inputs; a register-array model tracks the expected
//   architectural state (registers, aux, retire count).
module tb_alu_issue_unit;
   import alu_issue_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [1:0] instr_ra, instr_rb, instr_rd;
   logic [3:0] instr_imm;
   logic       instr_use_imm, instr_ld;
   logic [3:0] alu_a, alu_b, alu_opcode, alu_x, alu_y, aux, dbg_data;
   logic [1:0] dbg_addr;
   logic       busy, retire;
   logic [7:0] retire_count;

   logic       stub_const = 1'b0;
   logic [3:0] m_reg [4];
   logic [3:0] m_aux;
   logic [7:0] m_cnt;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   alu_issue_unit dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .instr_valid_i   (instr_valid),
      .instr_ready_o   (instr_ready),
      .instr_op_i      (instr_op),
      .instr_ra_i      (instr_ra),
      .instr_rb_i      (instr_rb),
      .instr_rd_i      (instr_rd),
      .instr_imm_i     (instr_imm),
      .instr_use_imm_i (instr_use_imm),
      .instr_ld_i      (instr_ld),
      .alu_a_o         (alu_a),
      .alu_b_o         (alu_b),
      .alu_opcode_o    (alu_opcode),
      .alu_x_i         (alu_x),
      .alu_y_i         (alu_y),
      .aux_o           (aux),
      .dbg_addr_i      (dbg_addr),
      .dbg_data_o      (dbg_data),
      .busy_o          (busy),
      .retire_o        (retire),
      .retire_count_o  (retire_count)
   );

   // Stub ALU: either the fixed C/1 answer or a simple arithmetic function.
   function automatic logic [3:0] stub_x(input logic [3:0] a, b, op);
      return stub_const ? 4'hC : 4'(a + b + op);
   endfunction
   function automatic logic [3:0] stub_y(input logic [3:0] a, b);
      return stub_const ? 4'h1 : (a ^ b);
   endfunction

   assign alu_x = stub_x(alu_a, alu_b, alu_opcode);
   assign alu_y = stub_y(alu_a, alu_b);

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
      m_aux = 4'h0;
      m_cnt = 8'h0;
   endtask

   task automatic scramble_inputs();
      instr_op      = 4'($urandom);
      instr_ra      = 2'($urandom);
      instr_rb      = 2'($urandom);
      instr_rd      = 2'($urandom);
      instr_imm     = 4'($urandom);
      instr_use_imm = 1'($urandom);
      instr_ld      = 1'($urandom);
   endtask

   // One complete instruction through IDLE -> ISSUE -> WB with checks at
   // every stage, updating the model at write-back.
   task automatic run_instr(input instr_t in);
      logic [3:0] ea, eb, ex, ey;
      logic       wb_ready;
`ifdef ALU_ISSUE_OVERLAP_EN
      wb_ready = 1'b1;
`else
      wb_ready = 1'b0;
`endif
      @(negedge clk);
      chk("ready_idle", 8'(instr_ready), 8'h1);
      instr_op = in.op; instr_ra = in.ra; instr_rb = in.rb; instr_rd = in.rd;
      instr_imm = in.imm; instr_use_imm = in.use_imm; instr_ld = in.ld;
      instr_valid = 1'b1;
      ea = m_reg[in.ra];
      eb = in.use_imm ? in.imm : m_reg[in.rb];
      @(posedge clk); #1;
      instr_valid = 1'b0;
      scramble_inputs();
      chk("issue_alu_a", 8'(alu_a), 8'(ea));
      chk("issue_alu_b", 8'(alu_b), 8'(eb));
      chk("issue_opcode", 8'(alu_opcode), 8'(in.op));
      chk("issue_busy", 8'(busy), 8'h1);
      chk("issue_ready", 8'(instr_ready), 8'h0);
      chk("issue_retire", 8'(retire), 8'h0);
      @(posedge clk); #1;
      chk("wb_retire", 8'(retire), 8'h1);
      chk("wb_ready", 8'(instr_ready), 8'(wb_ready));
      ex = stub_x(ea, eb, in.op);
      ey = stub_y(ea, eb);
      if (in.ld) m_reg[in.rd] = in.imm;
      else begin
         m_reg[in.rd] = ex;
         m_aux = ey;
      end
      m_cnt = m_cnt + 8'd1;
      @(posedge clk); #1;
      chk("done_retire", 8'(retire), 8'h0);
      chk("done_busy", 8'(busy), 8'h0);
      chk("retire_count", retire_count, m_cnt);
      chk("aux", 8'(aux), 8'(m_aux));
      dbg_addr = in.rd;
      #1;
      chk("dbg_rd", 8'(dbg_data), 8'(m_reg[in.rd]));
   endtask

   function automatic instr_t mk(input logic [3:0] op, input logic [1:0] ra, rb, rd,
                                 input logic [3:0] imm, input logic use_imm, ld);
      instr_t t;
      t.op = op; t.ra = ra; t.rb = rb; t.rd = rd;
      t.imm = imm; t.use_imm = use_imm; t.ld = ld;
      return t;
   endfunction

   initial begin
      instr_t     r;
      logic [3:0] ea;
      int         accepts;

      rst = 1'b1;
      instr_valid = 1'b0;
      dbg_addr = 2'd0;
      scramble_inputs();
      model_reset();
      repeat (2) @(posedge clk);

      // Reset release
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", 8'(instr_ready), 8'h1);
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_alu_a", 8'(alu_a), 8'h0);
      chk("rst_alu_b", 8'(alu_b), 8'h0);
      chk("rst_opcode", 8'(alu_opcode), 8'h0);
      chk("rst_count", retire_count, 8'h0);
      chk("rst_retire", 8'(retire), 8'h0);
      chk("rst_aux", 8'(aux), 8'h0);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk("rst_dbg", 8'(dbg_data), 8'h0);
      end

      // Loads: r1 <- 5, r2 <- 1
      run_instr(mk(4'd0, 2'd0, 2'd0, 2'd1, 4'd5, 1'b0, 1'b1));
      run_instr(mk(4'd0, 2'd0, 2'd0, 2'd2, 4'd1, 1'b0, 1'b1));
      dbg_addr = 2'd1; #1;
      chk("ld_r1", 8'(dbg_data), 8'h5);
      dbg_addr = 2'd2; #1;
      chk("ld_r2", 8'(dbg_data), 8'h1);
      chk("ld_aux", 8'(aux), 8'h0);

      // Register op with fixed stub answer: r3 <- C, aux <- 1
      stub_const = 1'b1;
      run_instr(mk(4'd0, 2'd1, 2'd2, 2'd3, 4'd0, 1'b0, 1'b0));
      dbg_addr = 2'd3; #1;
      chk("op_r3", 8'(dbg_data), 8'hC);
      chk("op_aux", 8'(aux), 8'h1);
      stub_const = 1'b0;

`ifndef ALU_ISSUE_OVERLAP_EN
      // instr_valid held high: accepts every third cycle
      @(negedge clk);
      instr_op = 4'd11; instr_ra = 2'd1; instr_rb = 2'd0; instr_rd = 2'd0;
      instr_imm = 4'd15; instr_use_imm = 1'b1; instr_ld = 1'b0;
      instr_valid = 1'b1;
      accepts = 0;
      ea = 4'h0;
      for (int k = 0; k < 9; k++) begin
         if (k % 3 == 0) begin
            chk("hold_ready_idle", 8'(instr_ready), 8'h1);
            ea = m_reg[1];
         end else if (k % 3 == 1) begin
            chk("hold_ready_issue", 8'(instr_ready), 8'h0);
            chk("hold_alu_a", 8'(alu_a), 8'(ea));
            chk("hold_alu_b", 8'(alu_b), 8'hF);
         end else begin
            chk("hold_ready_wb", 8'(instr_ready), 8'h0);
            chk("hold_retire", 8'(retire), 8'h1);
            m_reg[0] = stub_x(ea, 4'hF, 4'd11);
            m_aux = stub_y(ea, 4'hF);
            m_cnt = m_cnt + 8'd1;
         end
         if (instr_ready) accepts++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("hold_accepts", 8'(accepts), 8'd3);
      dbg_addr = 2'd0; #1;
      chk("hold_r0", 8'(dbg_data), 8'(m_reg[0]));
      chk("hold_count", retire_count, m_cnt);
`endif

      // Randomized instructions against the model
      for (int n = 0; n < 40; n++) begin
         r = mk(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
         run_instr(r);
      end

      // Reset during ISSUE drops the in-flight instruction
      @(negedge clk);
      instr_op = 4'd3; instr_ra = 2'd1; instr_rb = 2'd2; instr_rd = 2'd1;
      instr_imm = 4'd7; instr_use_imm = 1'b0; instr_ld = 1'b1;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("mid_busy_before", 8'(busy), 8'h1);
      rst = 1'b1;
      #1;
      chk("mid_ready", 8'(instr_ready), 8'h1);
      chk("mid_busy", 8'(busy), 8'h0);
      chk("mid_alu_a", 8'(alu_a), 8'h0);
      chk("mid_alu_b", 8'(alu_b), 8'h0);
      chk("mid_opcode", 8'(alu_opcode), 8'h0);
      chk("mid_count", retire_count, 8'h0);
      chk("mid_aux", 8'(aux), 8'h0);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk("mid_dbg", 8'(dbg_data), 8'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mid_no_retire", 8'(retire), 8'h0);
      end
      dbg_addr = 2'd1; #1;
      chk("mid_r1_unwritten", 8'(dbg_data), 8'h0);

      // 256 load retirements wrap the counter
      for (int n = 0; n < 256; n++) begin
         run_instr(mk(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                      4'($urandom), 1'($urandom), 1'b1));
      end
      chk("wrap_count", retire_count, 8'h0);

`ifdef ALU_ISSUE_OVERLAP_EN
      // Back-to-back: second instruction accepted in WB, forwarded operand
      stub_const = 1'b1;
      @(negedge clk);
      instr_op = 4'd0; instr_ra = 2'd0; instr_rb = 2'd0; instr_rd = 2'd3;
      instr_imm = 4'd0; instr_use_imm = 1'b0; instr_ld = 1'b0;
      instr_valid = 1'b1;
      @(negedge clk);
      chk("ovl_ready_issue", 8'(instr_ready), 8'h0);
      instr_op = 4'd1; instr_ra = 2'd3; instr_rd = 2'd0;
      @(negedge clk);
      chk("ovl_ready_wb", 8'(instr_ready), 8'h1);
      chk("ovl_retire_wb", 8'(retire), 8'h1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("ovl_fwd_alu_a", 8'(alu_a), 8'hC);
      chk("ovl_busy", 8'(busy), 8'h1);
      chk("ovl_opcode", 8'(alu_opcode), 8'h1);
      repeat (2) @(posedge clk);
      #1;
      dbg_addr = 2'd3; #1;
      chk("ovl_r3", 8'(dbg_data), 8'hC);
      chk("ovl_count", retire_count, 8'h2);
      stub_const = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
